// File: rtl/lock_pkg.sv
// Shared state encodings and code-digit selection for the keypad lock.
package lock_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ENTER   = 3'd1;
    localparam logic [2:0] CHECK   = 3'd2;
    localparam logic [2:0] OPEN    = 3'd3;
    localparam logic [2:0] ROUTE   = 3'd4;
    localparam logic [2:0] LOCKOUT = 3'd5;

    typedef enum logic [2:0] {
        StIdle    = IDLE,
        StEnter   = ENTER,
        StCheck   = CHECK,
        StOpen    = OPEN,
        StRoute   = ROUTE,
        StLockout = LOCKOUT
    } state_e;

    // Widest code / digit the helper supports; callers truncate to their own width.
    localparam int unsigned MaxCodeW  = 256;
    localparam int unsigned MaxDigitW = 32;

    // Digit i of a packed code with w-bit digits; digit 0 sits in the LSBs.
    function automatic logic [MaxDigitW-1:0] digit_at(input logic [MaxCodeW-1:0] code,
                                                      input int unsigned         i,
                                                      input int unsigned         w);
        return MaxDigitW'(code >> (i * w));
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Lockout down-counter: load with LOCK_CYCLES-1, decrement to zero and hold there.
module lock_timer #(
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int unsigned CntW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CntW-1:0] LoadVal = CntW'(LOCK_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LoadVal;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/param_lock_fsm.sv
// Moore password lock with failed-attempt counting and parity routing of data words.
// Timed lockout after MAX_TRIES failures is built only with PARAM_LOCK_LOCKOUT_EN defined.
module param_lock_fsm
    import lock_pkg::*;
#(
    parameter int unsigned                  DIGIT_W     = 4,
    parameter int unsigned                  PASS_LEN    = 4,
    parameter logic [DIGIT_W*PASS_LEN-1:0]  PASSWORD    = 16'h9A3C,
    parameter int unsigned                  MAX_TRIES   = 3,
    parameter int unsigned                  LOCK_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              confirm,
    input  logic [DIGIT_W-1:0]                pass_data,
    input  logic                              logout,
    output logic                              en_left,
    output logic                              en_right,
    output logic [DIGIT_W-1:0]                dout,
    output logic [2:0]                        state,
    output logic                              unlocked,
    output logic                              locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]    fail_cnt
);

    localparam int unsigned IdxW  = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;
    localparam int unsigned FailW = $clog2(MAX_TRIES + 1);

    localparam logic [IdxW-1:0]     IdxLast = IdxW'(PASS_LEN - 1);
    localparam logic [FailW-1:0]    FailMax = FailW'(MAX_TRIES);
    localparam logic [MaxCodeW-1:0] CodeExt = MaxCodeW'(PASSWORD);

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                mism_q, mism_d;
    logic [FailW-1:0]    fail_q, fail_d;
    logic [DIGIT_W-1:0]  dout_q, dout_d;

    logic [DIGIT_W-1:0]  exp_digit;
    logic [FailW-1:0]    fail_inc;

    assign exp_digit = DIGIT_W'(digit_at(CodeExt, 32'(idx_q), DIGIT_W));
    assign fail_inc  = (fail_q == FailMax) ? fail_q : fail_q + 1'b1;

`ifdef PARAM_LOCK_LOCKOUT_EN
    logic timer_load;
    logic timer_zero;

    lock_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .dec  (state_q == StLockout),
        .zero (timer_zero)
    );
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mism_d  = mism_q;
        fail_d  = fail_q;
        dout_d  = dout_q;
`ifdef PARAM_LOCK_LOCKOUT_EN
        timer_load = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                state_d = StEnter;
            end

            StEnter: begin
                // Mismatches accumulate silently so a wrong digit is not revealed early.
                if (confirm) begin
                    mism_d = mism_q | (pass_data != exp_digit);
                    if (idx_q == IdxLast) begin
                        idx_d   = '0;
                        state_d = StCheck;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            StCheck: begin
                mism_d = 1'b0;
                if (!mism_q) begin
                    fail_d  = '0;
                    state_d = StOpen;
                end else begin
                    fail_d  = fail_inc;
                    state_d = StEnter;
`ifdef PARAM_LOCK_LOCKOUT_EN
                    if (fail_inc == FailMax) begin
                        state_d    = StLockout;
                        timer_load = 1'b1;
                    end
`endif
                end
            end

            StOpen: begin
                if (logout) begin
                    state_d = StEnter;
                end else if (confirm) begin
                    dout_d  = pass_data;
                    state_d = StRoute;
                end
            end

            StRoute: begin
                state_d = StOpen;
            end

`ifdef PARAM_LOCK_LOCKOUT_EN
            StLockout: begin
                if (timer_zero) begin
                    fail_d  = '0;
                    state_d = StEnter;
                end
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            mism_q  <= 1'b0;
            fail_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mism_q  <= mism_d;
            fail_q  <= fail_d;
            dout_q  <= dout_d;
        end
    end

    // Strobes decode from ROUTE plus the parity of the registered word, so they can
    // only ever be high one at a time and only for the single ROUTE cycle.
    assign en_left   = (state_q == StRoute) &  dout_q[0];
    assign en_right  = (state_q == StRoute) & ~dout_q[0];
    assign dout      = dout_q;
    assign state     = state_q;
    assign unlocked  = (state_q == StOpen) | (state_q == StRoute);
    assign fail_cnt  = fail_q;
`ifdef PARAM_LOCK_LOCKOUT_EN
    assign locked_out = (state_q == StLockout);
`else
    assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_param_lock_fsm.sv
// Directed bench for param_lock_fsm with a cycle-level reference model of the lock rules.
module tb_param_lock_fsm;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned PASS_LEN    = 4;
    localparam logic [15:0] PW          = 16'h9A3C;
    localparam int unsigned MAX_TRIES   = 3;
    localparam int unsigned LOCK_CYCLES = 16;
    localparam int unsigned FW          = $clog2(MAX_TRIES + 1);
`ifdef PARAM_LOCK_LOCKOUT_EN
    localparam bit LOCKOUT_EN = 1'b1;
`else
    localparam bit LOCKOUT_EN = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               confirm;
    logic [DIGIT_W-1:0] pass_data;
    logic               logout;
    logic               en_left;
    logic               en_right;
    logic [DIGIT_W-1:0] dout;
    logic [2:0]         state;
    logic               unlocked;
    logic               locked_out;
    logic [FW-1:0]      fail_cnt;

    int checks = 0;
    int errors = 0;

    param_lock_fsm #(
        .DIGIT_W     (DIGIT_W),
        .PASS_LEN    (PASS_LEN),
        .PASSWORD    (PW),
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .confirm    (confirm),
        .pass_data  (pass_data),
        .logout     (logout),
        .en_left    (en_left),
        .en_right   (en_right),
        .dout       (dout),
        .state      (state),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole code collected then compared, lockout as cycles remaining.
    int          m_state;
    logic [15:0] m_code;
    int          m_ndig;
    int          m_fail;
    int          m_left;
    logic [3:0]  m_dout;

    always @(posedge clk or posedge rst) begin : model
        int nf;
        if (rst) begin
            m_state <= 0;
            m_code  <= '0;
            m_ndig  <= 0;
            m_fail  <= 0;
            m_left  <= 0;
            m_dout  <= '0;
        end else begin
            case (m_state)
                0: m_state <= 1;
                1: if (confirm) begin
                    m_code <= m_code | (16'(pass_data) << (4 * m_ndig));
                    if (m_ndig + 1 == PASS_LEN) begin
                        m_ndig  <= 0;
                        m_state <= 2;
                    end else begin
                        m_ndig <= m_ndig + 1;
                    end
                end
                2: begin
                    m_code <= '0;
                    if (m_code == PW) begin
                        m_fail  <= 0;
                        m_state <= 3;
                    end else begin
                        nf = (m_fail + 1 > MAX_TRIES) ? MAX_TRIES : m_fail + 1;
                        m_fail <= nf;
                        if (LOCKOUT_EN && nf == MAX_TRIES) begin
                            m_state <= 5;
                            m_left  <= LOCK_CYCLES;
                        end else begin
                            m_state <= 1;
                        end
                    end
                end
                3: if (logout) begin
                    m_state <= 1;
                end else if (confirm) begin
                    m_dout  <= pass_data;
                    m_state <= 4;
                end
                4: m_state <= 3;
                5: begin
                    if (m_left == 1) begin
                        m_state <= 1;
                        m_fail  <= 0;
                    end
                    m_left <= m_left - 1;
                end
                default: m_state <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("state",      state,      m_state);
        check("unlocked",   unlocked,   int'(m_state == 3 || m_state == 4));
        check("locked_out", locked_out, int'(m_state == 5));
        check("en_left",    en_left,    int'(m_state == 4 && m_dout[0]));
        check("en_right",   en_right,   int'(m_state == 4 && !m_dout[0]));
        check("dout",       dout,       m_dout);
        check("fail_cnt",   fail_cnt,   m_fail);
    end

    task automatic press(input logic [3:0] d);
        confirm   = 1'b1;
        pass_data = d;
        @(negedge clk);
        confirm = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Enter a 4-digit code, digit 0 first; returns one cycle after CHECK.
    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 3; i++) press(c[4*i +: 4]);
        check("entry_holds_enter", state, 1);
        confirm   = 1'b1;
        pass_data = c[15:12];
        @(negedge clk);
        confirm = 1'b0;
        check("check_state", state, 2);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst       = 1'b1;
        confirm   = 1'b0;
        logout    = 1'b0;
        pass_data = '0;
        repeat (3) @(negedge clk);
        check("lit_reset_state", state, 0);
        check("lit_reset_dout", dout, 0);
        check("lit_reset_fail", fail_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        check("lit_idle_to_enter", state, 1);

        // Correct code C,3,A,9
        enter_code(16'h9A3C);
        check("lit_open_state", state, 3);
        check("lit_open_unlocked", unlocked, 1);
        check("lit_open_fail", fail_cnt, 0);

        // Even word -> right bank
        pass_data = 4'h6;
        confirm   = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        check("lit_route6_en_right", en_right, 1);
        check("lit_route6_en_left", en_left, 0);
        check("lit_route6_dout", dout, 6);
        @(negedge clk);
        check("lit_route6_clear", en_right, 0);

        // Odd word -> left bank; confirm held into ROUTE must be ignored
        pass_data = 4'h7;
        confirm   = 1'b1;
        @(negedge clk);
        check("lit_route7_en_left", en_left, 1);
        check("lit_route7_en_right", en_right, 0);
        check("lit_route7_dout", dout, 7);
        pass_data = 4'h4;
        @(negedge clk);
        confirm = 1'b0;
        check("lit_route_ignored_state", state, 3);
        check("lit_route7_clear", en_left, 0);
        @(negedge clk);
        check("lit_dout_hold", dout, 7);

        // Logout beats confirm
        logout    = 1'b1;
        confirm   = 1'b1;
        pass_data = 4'h2;
        @(negedge clk);
        logout  = 1'b0;
        confirm = 1'b0;
        check("lit_logout_state", state, 1);
        check("lit_logout_no_strobe", int'(en_left | en_right), 0);
        check("lit_logout_dout", dout, 7);

        // Wrong first digit
        enter_code(16'h9A30);
        check("lit_fail1_state", state, 1);
        check("lit_fail1_cnt", fail_cnt, 1);
        check("lit_fail1_unlocked", unlocked, 0);
        enter_code(16'h9A30);
        check("lit_fail2_cnt", fail_cnt, 2);
        enter_code(16'h9A30);
`ifdef PARAM_LOCK_LOCKOUT_EN
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!locked_out) break;
            cnt++;
            confirm   = i[0];
            pass_data = 4'hC;
            @(negedge clk);
        end
        confirm = 1'b0;
        check("lit_lockout_cycles", cnt, LOCK_CYCLES);
        check("lit_after_lockout_state", state, 1);
        check("lit_after_lockout_fail", fail_cnt, 0);
`else
        cnt = 0;
        check("lit_no_lockout_state", state, 1);
        check("lit_no_lockout_locked", locked_out, cnt);
        check("lit_fail3_cnt", fail_cnt, 3);
        enter_code(16'h9A30);
        check("lit_fail_saturate", fail_cnt, 3);
`endif

        // Reset mid-entry discards the partial code
        press(4'hC);
        press(4'h3);
        #2 rst = 1'b1;
        #1;
        check("lit_async_reset_state", state, 0);
        check("lit_async_reset_fail", fail_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("lit_post_reset_enter", state, 1);
        enter_code(16'h9A3C);
        check("lit_post_reset_open", state, 3);
        check("lit_post_reset_unlocked", unlocked, 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_lock_fsm.md
Name: param_lock_fsm

Overview:
- Parametrised Moore-style password lock for the lab keypad datapath.
- Accepts a PASS_LEN-digit code, one DIGIT_W-bit digit per confirm pulse. The code is checked only after the last digit, so there is no early-fail leak.
- Counts failed attempts and can force a timed lockout.
- Once open, routes each confirmed data word to the left or right register bank by parity.

Parameters:
- DIGIT_W, 4: bits per digit / data word.
- PASS_LEN, 4: digits per code, >=1.
- PASSWORD, 16'h9A3C: code, DIGIT_W*PASS_LEN bits; digit i is PASSWORD[i*DIGIT_W +: DIGIT_W]; digit 0 is entered first.
- MAX_TRIES, 3: consecutive failures that trigger lockout, >=1.
- LOCK_CYCLES, 16: lockout duration in clk cycles, >=1.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- confirm, input, 1: single-cycle strobe; qualifies pass_data.
- pass_data, input, DIGIT_W: digit (entry) or data word (open).
- logout, input, 1: relock request while open.
- en_left, output, 1: one-cycle write strobe, odd words.
- en_right, output, 1: one-cycle write strobe, even words.
- dout, output, DIGIT_W: last routed word, registered.
- state, output, 3: current state encoding.
- unlocked, output, 1: high in OPEN and ROUTE.
- locked_out, output, 1: high in LOCKOUT.
- fail_cnt, output, $clog2(MAX_TRIES+1): consecutive failures.

Behaviour:
- Reset (async):
  - state = IDLE; all outputs 0.
  - Digit index = 0; mismatch flag = 0; lockout timer = 0.
- State encodings: IDLE=0, ENTER=1, CHECK=2, OPEN=3, ROUTE=4, LOCKOUT=5. Encodings 6 and 7 are illegal and go to IDLE on the next clk.
- IDLE: unconditional -> ENTER after 1 cycle.
- ENTER:
  - On confirm, compare pass_data with digit[idx]; mismatch flag |= (pass_data != digit[idx]); idx++.
  - On the confirm with idx == PASS_LEN-1: -> CHECK, idx = 0.
  - Without confirm: hold.
- CHECK (1 cycle; confirm ignored):
  - Mismatch flag clear: -> OPEN, fail_cnt = 0.
  - Mismatch flag set: fail_cnt++. If the new value equals MAX_TRIES -> LOCKOUT and load the timer with LOCK_CYCLES-1; else -> ENTER.
  - Mismatch flag is cleared on leaving CHECK.
- LOCKOUT:
  - Timer decrements each cycle; confirm ignored.
  - At timer == 0: -> ENTER, fail_cnt = 0.
  - Total time in LOCKOUT is exactly LOCK_CYCLES cycles.
- OPEN:
  - logout has priority over confirm: -> ENTER, no strobe.
  - Otherwise on confirm: dout <= pass_data; en_right <= ~pass_data[0]; en_left <= pass_data[0]; -> ROUTE.
- ROUTE (1 cycle):
  - Strobes are visible for exactly this cycle, then clear.
  - Return to OPEN; confirm in this cycle is ignored. Back-to-back words therefore need a confirm gap of at least 1 cycle.
- en_left and en_right are never high together and are high only in ROUTE.
- dout holds its value until the next routed word or reset.
- fail_cnt saturates at MAX_TRIES and never wraps.
- Reset asserted mid-entry or mid-lockout: everything returns to reset values immediately; a partial code is discarded.

Optional Feature:
- Macro: PARAM_LOCK_LOCKOUT_EN.
- Defined: LOCKOUT state, timer, and locked_out behave as above.
- Undefined:
  - No timer logic; locked_out is tied to 0.
  - CHECK on failure always -> ENTER.
  - fail_cnt still counts and saturates at MAX_TRIES.

Decomposition:
- Package lock_pkg: state encodings (IDLE..LOCKOUT as 3-bit localparams) and a digit-select helper function digit_at(code, i).
- Sub-module lock_timer: load/decrement/zero-flag down-counter, LOCK_CYCLES-parametrised. Instantiated only under PARAM_LOCK_LOCKOUT_EN.

Test Plan:
- Reset then confirm digits C,3,A,9 (one per 3 cycles) -> IDLE, ENTER, CHECK, then OPEN; unlocked=1; fail_cnt=0.
- Wrong digit first (0,3,A,9) -> no state change until the 4th confirm; CHECK then ENTER; fail_cnt=1; unlocked=0.
- Three wrong codes (macro defined) -> LOCKOUT; locked_out high for exactly 16 cycles; confirms ignored; then ENTER with fail_cnt=0. With the macro undefined -> ENTER, fail_cnt=3.
- In OPEN, confirm with 4'h6 then 4'h7 -> en_right pulse with dout=6, then en_left pulse with dout=7; each pulse 1 cycle; dout stays 7.
- In OPEN, logout and confirm in the same cycle -> ENTER; no strobe; dout unchanged.
- Assert rst after 2 correct digits, then enter the full correct code -> OPEN; the partial entry had no effect.
